// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter-side signal bundle for the UART transmit arbiter.
// master: requesters plus UART transmitter view; slave: the arbiter itself.
interface uart_tx_arb_if;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  last;
    logic        tx_rdy;
    logic        tx_en;
    logic [7:0]  dout;
    logic [3:0]  ack;
    logic [1:0]  owner;
    logic        locked;
    logic        busy;

    modport master (
        output req, data_in, last, tx_rdy,
        input  tx_en, dout, ack, owner, locked, busy
    );

    modport slave (
        input  req, data_in, last, tx_rdy,
        output tx_en, dout, ack, owner, locked, busy
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmit path among four byte requesters,
// with packet locking and a guard timeout for a transmitter that never drops tx_rdy.
module uart_tx_arb #(
    parameter int unsigned GUARD = 16
) (
    input logic         clk,
    input logic         rst,
    uart_tx_arb_if.slave bus
);

    typedef enum logic [1:0] {StArb, StWaitLo, StWaitHi} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] dout_q, dout_d;
    logic       tx_en_q, tx_en_d;
    logic [3:0] ack_q, ack_d;
    logic [1:0] owner_q, owner_d;
    logic       locked_q, locked_d;

    logic [1:0] cand;
    logic [1:0] idx;
    logic       cand_ok;

    // Owner is searched last so the most recent winner has lowest priority.
    always_comb begin
        cand    = owner_q;
        cand_ok = 1'b0;
        idx     = owner_q;
        if (locked_q) begin
            cand_ok = bus.req[owner_q];
        end else begin
            for (int k = 1; k <= 4; k++) begin
                idx = owner_q + 2'(k);
                if (!cand_ok && bus.req[idx]) begin
                    cand    = idx;
                    cand_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        tx_en_d  = 1'b0;
        ack_d    = 4'b0000;
        owner_d  = owner_q;
        locked_d = locked_q;
        unique case (state_q)
            StArb: begin
                if (locked_q && !bus.req[owner_q]) begin
                    // Owner abandoned its packet: spend this cycle releasing the lock.
                    locked_d = 1'b0;
                end else if (cand_ok && bus.tx_rdy) begin
                    dout_d       = bus.data_in[{cand, 3'b000} +: 8];
                    tx_en_d      = 1'b1;
                    ack_d[cand]  = 1'b1;
                    owner_d      = cand;
                    locked_d     = ~bus.last[cand];
                    cnt_d        = 8'd0;
                    state_d      = StWaitLo;
                end
            end
            StWaitLo: begin
                if (!bus.tx_rdy) begin
                    state_d = StWaitHi;
                end else if (cnt_q == 8'(GUARD - 1)) begin
                    state_d = StArb;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StWaitHi: begin
                if (bus.tx_rdy) begin
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StArb;
            cnt_q    <= 8'd0;
            dout_q   <= 8'd0;
            tx_en_q  <= 1'b0;
            ack_q    <= 4'b0000;
            owner_q  <= 2'd3;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            tx_en_q  <= tx_en_d;
            ack_q    <= ack_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
        end
    end

    assign bus.tx_en  = tx_en_q;
    assign bus.dout   = dout_q;
    assign bus.ack    = ack_q;
    assign bus.owner  = owner_q;
    assign bus.locked = locked_q;
    assign bus.busy   = (state_q != StArb);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: transaction-level requester/transmitter model with randomized
// traffic plus directed scenarios for reset, round robin, packet lock and guard timing.
module tb_uart_tx_arb;

    localparam int unsigned GUARD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arb_if bus ();

    uart_tx_arb #(.GUARD(GUARD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Requester packet queues: {last, byte}
    logic [8:0] pq [4][$];
    int         log_idx[$];
    int         log_cyc[$];
    int         log_byte[$];

    int         n = 0;
    int         arb_from = 0;
    int         lo_s = 0;
    int         lo_e = 0;
    int         m_owner = 3;
    bit         m_locked = 0;
    int         m_dout = 0;
    bit         exp_tx = 0;
    int         exp_idx = 0;
    int         mode = 0;  // 0 random, 1 guard only, 2 drop one cycle after tx_en for 20 cycles
    bit         rand_fill = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, n);
        end
    endtask

    function automatic bit model_idle();
        for (int i = 0; i < 4; i++) if (pq[i].size() != 0) return 0;
        return !exp_tx && (n >= arb_from);
    endfunction

    task automatic drive_decide();
        logic [3:0]  rv;
        logic [3:0]  lv;
        logic [31:0] dv;
        int          cand;
        int          c;
        int          j;
        int          len;
        rv = '0;
        lv = '0;
        dv = '0;
        if (rand_fill) begin
            for (int i = 0; i < 4; i++) begin
                if (pq[i].size() == 0 && $urandom_range(3) == 0) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) pq[i].push_back({b == len - 1, 8'($urandom)});
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pq[i].size() != 0) begin
                rv[i]          = 1'b1;
                dv[8*i +: 8]   = pq[i][0][7:0];
                lv[i]          = pq[i][0][8];
            end
        end
        bus.req     = rv;
        bus.data_in = dv;
        bus.last    = lv;
        if (n < arb_from) bus.tx_rdy = !(n >= lo_s && n < lo_e);
        else bus.tx_rdy = (mode == 0) ? ($urandom_range(7) != 0) : 1'b1;

        exp_tx = 0;
        if (n >= arb_from) begin
            if (m_locked && !rv[m_owner]) begin
                m_locked = 0;
            end else begin
                cand = -1;
                if (m_locked) cand = m_owner;
                else begin
                    for (int k = 1; k <= 4; k++)
                        if (cand < 0 && rv[(m_owner + k) % 4]) cand = (m_owner + k) % 4;
                end
                if (cand >= 0 && bus.tx_rdy) begin
                    exp_tx   = 1;
                    exp_idx  = cand;
                    m_dout   = int'(dv[8*cand +: 8]);
                    m_owner  = cand;
                    m_locked = !lv[cand];
                    c        = n + 1;
                    if (mode == 1 || (mode == 0 && $urandom_range(3) == 0)) begin
                        lo_s     = 0;
                        lo_e     = 0;
                        arb_from = c + GUARD;
                    end else begin
                        j        = (mode == 2) ? 1 : $urandom_range(3);
                        len      = (mode == 2) ? 20 : $urandom_range(1, 6);
                        lo_s     = c + j;
                        lo_e     = lo_s + len;
                        arb_from = lo_e + 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        n++;
        if (bus.tx_en) begin
            for (int i = 0; i < 4; i++) if (bus.ack[i]) log_idx.push_back(i);
            log_cyc.push_back(n);
            log_byte.push_back(int'(bus.dout));
        end
        if (exp_tx) begin
            check_eq("tx_en", int'(bus.tx_en), 1);
            check_eq("ack", int'(bus.ack), 1 << exp_idx);
            if (pq[exp_idx].size() != 0) void'(pq[exp_idx].pop_front());
        end else begin
            check_eq("tx_en_idle", int'(bus.tx_en), 0);
            check_eq("ack_idle", int'(bus.ack), 0);
        end
        check_eq("owner", int'(bus.owner), m_owner);
        check_eq("locked", int'(bus.locked), int'(m_locked));
        check_eq("dout", int'(bus.dout), m_dout);
        check_eq("busy", int'(bus.busy), int'(n < arb_from));
        drive_decide();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        bus.req     = '0;
        bus.last    = '0;
        bus.data_in = '0;
        bus.tx_rdy  = 1'b1;
        for (int i = 0; i < 4; i++) pq[i].delete();
        repeat (2) @(negedge clk);
        n += 3;
        m_owner  = 3;
        m_locked = 0;
        m_dout   = 0;
        arb_from = 0;
        lo_s     = 0;
        lo_e     = 0;
        exp_tx   = 0;
        log_idx.delete();
        log_cyc.delete();
        log_byte.delete();
        check_eq("rst_tx_en", int'(bus.tx_en), 0);
        check_eq("rst_ack", int'(bus.ack), 0);
        check_eq("rst_dout", int'(bus.dout), 0);
        check_eq("rst_owner", int'(bus.owner), 3);
        check_eq("rst_locked", int'(bus.locked), 0);
        check_eq("rst_busy", int'(bus.busy), 0);
        rst = 1'b0;
        drive_decide();
    endtask

    task automatic run_until_idle(input int max_cyc);
        int k = 0;
        while (k < max_cyc && !model_idle()) begin
            step();
            k++;
        end
        check_eq("drain_timeout", int'(model_idle()), 1);
    endtask

    task automatic wait_grants(input int cnt, input int max_cyc);
        int k = 0;
        while (k < max_cyc && log_idx.size() < cnt) begin
            step();
            k++;
        end
        check_eq("grant_timeout", int'(log_idx.size() >= cnt), 1);
    endtask

    int t_req;
    int exp_lock_order[5] = '{1, 1, 1, 3, 0};

    initial begin
        bus.req     = '0;
        bus.data_in = '0;
        bus.last    = '0;
        bus.tx_rdy  = 1'b1;

        // Reset then idle
        mode = 1;
        do_reset();
        repeat (10) step();
        check_eq("idle_no_grant", log_idx.size(), 0);

        // Single byte with transmitter dropping tx_rdy for 20 cycles
        mode = 2;
        do_reset();
        pq[2].push_back({1'b1, 8'hA5});
        t_req = n + 1;
        wait_grants(1, 10);
        check_eq("single_latency", log_cyc[0] - t_req, 1);
        check_eq("single_idx", log_idx[0], 2);
        check_eq("single_byte", log_byte[0], 8'hA5);
        run_until_idle(100);

        // Round robin
        mode = 1;
        do_reset();
        for (int i = 0; i < 4; i++) pq[i].push_back({1'b1, 8'(8'h10 + i)});
        run_until_idle(200);
        check_eq("rr_count", log_idx.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("rr_order", log_idx[i], i);
            check_eq("rr_byte", log_byte[i], 8'h10 + i);
        end
        check_eq("guard_spacing", log_cyc[1] - log_cyc[0], GUARD + 1);

        // Packet lock
        do_reset();
        pq[1].push_back({1'b0, 8'h21});
        pq[1].push_back({1'b0, 8'h22});
        pq[1].push_back({1'b1, 8'h23});
        wait_grants(1, 10);
        pq[0].push_back({1'b1, 8'h30});
        pq[3].push_back({1'b1, 8'h33});
        run_until_idle(300);
        check_eq("lock_count", log_idx.size(), 5);
        for (int i = 0; i < 5; i++) check_eq("lock_order", log_idx[i], exp_lock_order[i]);

        // Lock release when owner drops its request
        do_reset();
        pq[2].push_back({1'b0, 8'h42});
        wait_grants(1, 10);
        pq[0].push_back({1'b1, 8'h40});
        run_until_idle(200);
        check_eq("drop_count", log_idx.size(), 2);
        check_eq("drop_second", log_idx[1], 0);
        check_eq("drop_spacing", log_cyc[1] - log_cyc[0], GUARD + 2);

        // Reset in WAIT_HI
        mode = 2;
        do_reset();
        pq[1].push_back({1'b1, 8'h5A});
        wait_grants(1, 10);
        repeat (4) step();
        check_eq("waithi_busy", int'(bus.busy), 1);
        do_reset();
        repeat (5) step();
        check_eq("post_rst_no_resend", log_idx.size(), 0);

        // Randomized traffic
        mode = 0;
        do_reset();
        rand_fill = 1;
        repeat (3000) step();
        rand_fill = 0;
        run_until_idle(2000);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter sharing the single UART transmit path of the UART controller among four byte requesters. It sits between the requesters (I/O controller, status reporter, echo path, debug) and the UART controller's transmit inputs (`din`, `tx_en`, `tx_rdy`). It issues one byte at a time, waits for the transmitter to complete, and keeps multi-byte packets from interleaving by locking the grant to one requester until that requester's last byte.

## Interface
- `GUARD`, default 16: cycles to wait for `tx_rdy` to fall after a `tx_en` pulse before the byte is treated as sent (deadlock guard); legal range 2..255.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  4  per-requester byte request; bit i belongs to requester i.
- `data_in`  in  32  requester i byte on `data_in[8i+7:8i]`; must be stable while `req[i]`=1 and until `ack[i]`.
- `last`  in  4  `last[i]`=1 marks the presented byte as the final byte of requester i's packet.
- `tx_rdy`  in  1  transmitter idle/ready (from UART controller).
- `tx_en`  out  1  one-cycle pulse: `dout` is valid, start transmission.
- `dout`  out  8  byte to transmitter; holds its value until the next grant.
- `ack`  out  4  one-cycle pulse on bit i: requester i's byte is accepted; present the next byte or drop `req[i]`.
- `owner`  out  2  index of the most recently granted requester.
- `locked`  out  1  grant is held by `owner` mid-packet.
- `busy`  out  1  transfer in flight (state != ARB).

## Operation
- States: ARB, WAIT_LO, WAIT_HI. Reset state ARB.
- Reset values: `tx_en`=0, `dout`=0, `ack`=0, `owner`=3, `locked`=0, `busy`=0, guard counter=0.
- ARB, unlocked: the candidate is the first i with `req[i]`=1, searching `owner`+1, `owner`+2, … mod 4. `owner` itself is searched last.
- ARB, locked: the only candidate is `owner`. If `req[owner]`=0, clear `locked` this cycle and make no grant; arbitration resumes next cycle. This costs one cycle.
- Grant, when a candidate exists and `tx_rdy`=1, registered on the edge:
  - `dout`←candidate byte; `tx_en`←1; `ack[cand]`←1; `owner`←cand.
  - `locked`←~`last[cand]`; counter←0; go to WAIT_LO.
- `tx_rdy`=0 in ARB: no grant; requests keep pending; no state change.
- WAIT_LO:
  - `tx_rdy`=0 → WAIT_HI.
  - Otherwise, counter = GUARD-1 → ARB (byte treated as sent).
  - Otherwise counter+1 (8-bit, never wraps within range).
- WAIT_HI: `tx_rdy`=1 → ARB; otherwise stay. There is no timeout in WAIT_HI.
- `req` and `last` are ignored outside ARB. A `req` dropped before `ack` is never granted.
- At most one `ack` bit is set per cycle. `ack` and `tx_en` always pulse together.
- `rst` mid-transfer returns to ARB with all reset values. No pending byte is re-sent.

## Timing
- Grant latency: `req` sampled in ARB at edge k → `tx_en`/`ack` high during cycle k+1 only.
- Minimum byte spacing: 1 (ARB) + WAIT_LO cycles + WAIT_HI cycles.
  - Guard path: back-to-back grants are GUARD+1 cycles apart.
- `tx_en` is high during the first WAIT_LO cycle. The transmitter samples `dout` then.
- Requester holds `data_in`/`last` until it sees `ack`. It may change them in the cycle after `ack`, since the arbiter is not in ARB then.
- `busy`, `locked` and `owner` are registered and update on the grant edge.
- Fairness: with all four requesting single-byte packets continuously, grant order is 0,1,2,3,0,…

## Test plan
- Reset then idle: hold `rst` 2 cycles, `req`=0 → all outputs at reset values; `tx_en` never pulses.
- Single byte: `req`=4'b0100, byte 8'hA5, `last`=1, `tx_rdy`=1; model drops `tx_rdy` 1 cycle after `tx_en` for 20 cycles →
  - `tx_en`+`ack`=4'b0100 one cycle after request; `dout`=8'hA5; `owner`=2; `locked`=0.
  - Next grant no earlier than `tx_rdy` return.
- Round robin: `req`=4'b1111 continuously, all `last`=1 → four grants in order 0,1,2,3 with bytes 8'h10,8'h11,8'h12,8'h13.
- Packet lock: requester 1 sends 3 bytes (`last`=0,0,1) while `req[0]` and `req[3]` are held → bytes 1,1,1 issued consecutively, then requester 3, then requester 0.
- Lock release on drop: requester 2 sends byte with `last`=0, then drops `req[2]`; `req[0]`=1 → `locked` clears in ARB; requester 0 granted the cycle after.
- Guard and reset: `tx_rdy` stuck at 1 with GUARD=16 → grants exactly 17 cycles apart. Assert `rst` during WAIT_HI → next cycle state ARB, `busy`=0, `owner`=3.
